// File: rtl/huff_lut_builder.sv
// Canonical-Huffman LUT builder: counts code lengths, derives canonical codes and
// fills a direct-mapped 2^MAX_LEN-entry table with {len, symbol} entries.
module huff_lut_builder #(
    parameter int unsigned  MAX_LEN  = 9,
    parameter int unsigned  SYM_W    = 9,
    parameter bit           CLEAR_EN = 1'b1,
    localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [SYM_W:0]         sym_num,
    input  logic [8:0]             len_base,
    input  logic                   rev,
    output logic [8:0]             len_raddr,
    input  logic [4:0]             len_rdata,
    output logic [MAX_LEN-1:0]     lut_waddr,
    output logic [LEN_W+SYM_W-1:0] lut_wdata,
    output logic                   lut_we,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   incomplete
);
    localparam int unsigned NLEN   = 1 << LEN_W;
    localparam int unsigned CNT_W  = SYM_W + 1;
    localparam int unsigned CODE_W = MAX_LEN + SYM_W + 2;
    // Wide enough that one step of (left<<1)-count can never wrap.
    localparam int unsigned LFT_W  = MAX_LEN + SYM_W + 3;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_COUNT, S_NEXTCODE, S_ASSIGN, S_FILL, S_FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          sym_num_q, iss_q, aidx_q, cnt_num;
    logic [8:0]                base_q, cnt_base;
    logic                      rev_q, rv_q, rv2_q, count_issue;
    logic [MAX_LEN-1:0]        clr_q, fill_q, fill_max, fill_addr, cur_code;
    logic [CNT_W-1:0]          bl_count [NLEN];
    logic [MAX_LEN-1:0]        next_code [NLEN];
    logic [LEN_W-1:0]          lvl_q, cur_len, rd_len;
    logic [SYM_W-1:0]          cur_sym;
    logic [CODE_W-1:0]         code_q, code_nx;
    logic signed [LFT_W-1:0]   left_q, left_nx, left_fin;

    function automatic logic [MAX_LEN-1:0] bit_rev(input logic [MAX_LEN-1:0] a);
        logic [MAX_LEN-1:0] r;
        for (int i = 0; i < int'(MAX_LEN); i++) r[i] = a[int'(MAX_LEN) - 1 - i];
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic plus the shared arithmetic of the code/fill datapath.
    always_comb begin
        state_d     = state_q;
        count_issue = 1'b0;
        cnt_base    = (state_q == S_IDLE) ? len_base : base_q;
        cnt_num     = (state_q == S_IDLE) ? sym_num : sym_num_q;
        rd_len      = LEN_W'(len_rdata);
        code_nx     = (code_q + CODE_W'(bl_count[lvl_q - LEN_W'(1)])) << 1;
        left_nx     = (left_q <<< 1) - $signed(LFT_W'(bl_count[lvl_q]));
        left_fin    = left_q[LFT_W-1] ? left_q : left_nx;
        fill_max    = MAX_LEN'((32'd1 << (MAX_LEN - 32'(cur_len))) - 32'd1);
        fill_addr   = (cur_code << (MAX_LEN - 32'(cur_len))) | fill_q;
        case (state_q)
            S_IDLE:     if (start) state_d = CLEAR_EN ? S_CLEAR : S_COUNT;
            S_CLEAR:    if (&clr_q) state_d = S_COUNT;
            S_COUNT:    if (!rv_q) state_d = S_NEXTCODE;
            S_NEXTCODE: if (lvl_q == LEN_W'(MAX_LEN))
                            state_d = (err || left_fin[LFT_W-1]) ? S_FIN : S_ASSIGN;
            S_ASSIGN:   if (aidx_q >= sym_num_q)  state_d = S_FIN;
                        else if (len_rdata != 5'd0) state_d = S_FILL;
            S_FILL:     if (fill_q == fill_max) state_d = S_ASSIGN;
            S_FIN:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        count_issue = (state_d == S_COUNT) && (iss_q < cnt_num);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_num_q <= '0; base_q <= '0; rev_q <= 1'b0;
            iss_q <= '0; aidx_q <= '0; rv_q <= 1'b0; rv2_q <= 1'b0;
            clr_q <= '0; fill_q <= '0; cur_code <= '0; cur_len <= '0; cur_sym <= '0;
            lvl_q <= '0; code_q <= '0; left_q <= '0;
            for (int i = 0; i < int'(NLEN); i++) begin
                bl_count[i]  <= '0;
                next_code[i] <= '0;
            end
            len_raddr <= '0; lut_waddr <= '0; lut_wdata <= '0; lut_we <= 1'b0;
            busy <= 1'b0; done <= 1'b0; err <= 1'b0; incomplete <= 1'b0;
        end else begin
            lut_we <= 1'b0;
            busy   <= (state_d != S_IDLE);
            done   <= (state_d == S_FIN);
            rv_q   <= count_issue;
            rv2_q  <= rv_q;

            if (state_q == S_IDLE && start) begin
                sym_num_q  <= sym_num;
                base_q     <= len_base;
                rev_q      <= rev;
                err        <= 1'b0;
                incomplete <= 1'b0;
                clr_q      <= '0;
                for (int i = 0; i < int'(NLEN); i++) bl_count[i] <= '0;
            end

            if (state_q == S_CLEAR) begin
                lut_we    <= 1'b1;
                lut_waddr <= clr_q;
                lut_wdata <= '0;
                clr_q     <= clr_q + MAX_LEN'(1);
            end

            // Length reads are pipelined: address now, data two edges later in rv2_q.
            if (count_issue) begin
                len_raddr <= cnt_base + 9'(iss_q);
                iss_q     <= iss_q + CNT_W'(1);
            end
            if (state_q == S_COUNT && rv2_q) begin
                if (len_rdata > 5'(MAX_LEN))
                    err <= 1'b1;
                else if (len_rdata != 5'd0)
                    bl_count[rd_len] <= bl_count[rd_len] + CNT_W'(1);
            end

            if (state_q == S_COUNT && state_d == S_NEXTCODE) begin
                lvl_q     <= LEN_W'(1);
                code_q    <= '0;
                left_q    <= LFT_W'(1);
                iss_q     <= '0;
                aidx_q    <= '0;
                len_raddr <= base_q;
            end

            if (state_q == S_NEXTCODE) begin
                next_code[lvl_q] <= MAX_LEN'(code_nx);
                code_q           <= code_nx;
                lvl_q            <= lvl_q + LEN_W'(1);
                if (!left_q[LFT_W-1]) left_q <= left_nx;
                if (left_fin[LFT_W-1]) err <= 1'b1;
                if (lvl_q == LEN_W'(MAX_LEN))
                    incomplete <= !left_fin[LFT_W-1] && (left_fin != '0);
                // Prefetch one symbol ahead so ASSIGN sees each length on arrival.
                if (state_d == S_ASSIGN) len_raddr <= base_q + 9'd1;
            end

            if (state_q == S_ASSIGN && state_d != S_FIN) begin
                aidx_q <= aidx_q + CNT_W'(1);
                if (len_rdata != 5'd0) begin
                    cur_code          <= next_code[rd_len];
                    next_code[rd_len] <= next_code[rd_len] + MAX_LEN'(1);
                    cur_len           <= rd_len;
                    cur_sym           <= SYM_W'(aidx_q);
                    fill_q            <= '0;
                end else begin
                    len_raddr <= base_q + 9'(aidx_q) + 9'd2;
                end
            end

            if (state_q == S_FILL) begin
                lut_we    <= 1'b1;
                lut_waddr <= rev_q ? bit_rev(fill_addr) : fill_addr;
                lut_wdata <= {cur_len, cur_sym};
                fill_q    <= fill_q + MAX_LEN'(1);
                if (state_d == S_ASSIGN) len_raddr <= base_q + 9'(aidx_q) + 9'd1;
            end
        end
    end
endmodule

// File: tb/tb_huff_lut_builder.sv
// Directed bench for huff_lut_builder (MAX_LEN=3): expected LUT writes and build
// results are queued at stimulus time and checked as the DUT emits them.
module tb_huff_lut_builder;
    localparam int unsigned MAX_LEN = 3;
    localparam int unsigned SYM_W   = 4;
    localparam int unsigned LEN_W   = 2;
    localparam int unsigned DW      = LEN_W + SYM_W;

    typedef struct packed {
        logic [MAX_LEN-1:0] a;
        logic [DW-1:0]      d;
    } wr_t;
    typedef struct packed {
        logic e;
        logic i;
    } res_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic [SYM_W:0]     sym_num = '0;
    logic [8:0]         len_base = '0;
    logic               rev = 1'b0;
    logic [8:0]         len_raddr;
    logic [4:0]         len_rdata;
    logic [MAX_LEN-1:0] lut_waddr;
    logic [DW-1:0]      lut_wdata;
    logic               lut_we, busy, done, err, incomplete;

    logic [4:0] lmem [512];
    wr_t        exp_w [$];
    res_t       exp_r [$];
    int         errors = 0;
    int         checks = 0;
    int         done_cnt = 0;

    huff_lut_builder #(.MAX_LEN(MAX_LEN), .SYM_W(SYM_W), .CLEAR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sym_num(sym_num),
        .len_base(len_base), .rev(rev), .len_raddr(len_raddr), .len_rdata(len_rdata),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .lut_we(lut_we),
        .busy(busy), .done(done), .err(err), .incomplete(incomplete)
    );

    always #5 clk = ~clk;
    always @(posedge clk) len_rdata <= lmem[len_raddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every write and every done pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (lut_we) begin
                if (exp_w.size() == 0) chk("unexpected_write", 32'(lut_waddr), 32'hFFFF);
                else begin
                    wr_t e;
                    e = exp_w.pop_front();
                    chk("wr_addr", 32'(lut_waddr), 32'(e.a));
                    chk("wr_data", 32'(lut_wdata), 32'(e.d));
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_r.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
                else begin
                    res_t r;
                    r = exp_r.pop_front();
                    chk("done_err", 32'(err), 32'(r.e));
                    chk("done_incomplete", 32'(incomplete), 32'(r.i));
                end
            end
        end
    end

    function automatic logic [MAX_LEN-1:0] rev3(input logic [MAX_LEN-1:0] a);
        return {a[0], a[1], a[2]};
    endfunction

    task automatic push_clear();
        for (int k = 0; k < 8; k++) exp_w.push_back('{a: MAX_LEN'(k), d: '0});
    endtask

    task automatic push_sym(input int first, input int cnt, input int len, input int sym,
                            input bit r);
        logic [MAX_LEN-1:0] a;
        for (int k = 0; k < cnt; k++) begin
            a = MAX_LEN'(first + k);
            exp_w.push_back('{a: (r ? rev3(a) : a), d: {LEN_W'(len), SYM_W'(sym)}});
        end
    endtask

    task automatic push_2133(input bit r);
        push_sym(4, 2, 2, 0, r);
        push_sym(0, 4, 1, 1, r);
        push_sym(6, 1, 3, 2, r);
        push_sym(7, 1, 3, 3, r);
    endtask

    task automatic do_start(input int base, input int n, input bit r);
        @(negedge clk);
        len_base = 9'(base);
        sym_num  = (SYM_W+1)'(n);
        rev      = r;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_writes_left"}, 32'(exp_w.size()), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        int n;
        for (int i = 0; i < 512; i++) lmem[i] = 5'd0;
        lmem[16] = 5'd2; lmem[17] = 5'd1; lmem[18] = 5'd3; lmem[19] = 5'd3;
        lmem[40] = 5'd1; lmem[41] = 5'd1; lmem[42] = 5'd1;
        lmem[60] = 5'd1; lmem[61] = 5'd2;
        lmem[80] = 5'd4; lmem[81] = 5'd1;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(lut_we), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_incomplete", 32'(incomplete), 32'd0);
        chk("rst_raddr", 32'(len_raddr), 32'd0);
        rst_n = 1'b1;

        // Complete code {2,1,3,3}, normal addressing
        push_clear(); push_2133(1'b0); exp_r.push_back('{e: 1'b0, i: 1'b0});
        d0 = done_cnt; do_start(16, 4, 1'b0);
        chk("a_busy", 32'(busy), 32'd1);
        wait_done("a", d0);

        // Same code, bit-reversed addressing
        push_clear(); push_2133(1'b1); exp_r.push_back('{e: 1'b0, i: 1'b0});
        d0 = done_cnt; do_start(16, 4, 1'b1);
        wait_done("b", d0);

        // Oversubscribed {1,1,1}: clear only, err
        push_clear(); exp_r.push_back('{e: 1'b1, i: 1'b0});
        d0 = done_cnt; do_start(40, 3, 1'b0);
        wait_done("c", d0);

        // Incomplete {1,2}, with a start pulse while busy that must be ignored
        push_clear(); push_sym(0, 4, 1, 0, 1'b0); push_sym(4, 2, 2, 1, 1'b0);
        exp_r.push_back('{e: 1'b0, i: 1'b1});
        d0 = done_cnt; do_start(60, 2, 1'b0);
        repeat (3) @(negedge clk);
        chk("d_busy_mid", 32'(busy), 32'd1);
        len_base = 9'd16; sym_num = 5'd4; rev = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("d", d0);

        // Length above MAX_LEN {4,1}: err; remaining code space leaves incomplete set
        push_clear(); exp_r.push_back('{e: 1'b1, i: 1'b1});
        d0 = done_cnt; do_start(80, 2, 1'b0);
        wait_done("e", d0);

        // Empty symbol set
        push_clear(); exp_r.push_back('{e: 1'b0, i: 1'b1});
        d0 = done_cnt; do_start(100, 0, 1'b0);
        wait_done("f", d0);

        // Reset in the middle of FILL, then rebuild from scratch
        push_clear(); push_2133(1'b0);
        do_start(16, 4, 1'b0);
        n = 0;
        while (!(lut_we && lut_wdata != '0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("g_fill_reached", 32'(n < 100), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("g_rst_we", 32'(lut_we), 32'd0);
        chk("g_rst_busy", 32'(busy), 32'd0);
        exp_w.delete(); exp_r.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_clear(); push_2133(1'b0); exp_r.push_back('{e: 1'b0, i: 1'b0});
        d0 = done_cnt; do_start(16, 4, 1'b0);
        wait_done("h", d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
